// File: rtl/hdmi_tx_reset_sequencer_if.sv
// hdmi_tx_reset_sequencer_if: Avalon-MM register port of the HDMI TX reset sequencer
// address/chipselect/write_n/writedata driven by the master, readdata by the slave (zero wait state).
interface hdmi_tx_reset_sequencer_if;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    modport master (output address, chipselect, write_n, writedata, input readdata);
    modport slave  (input address, chipselect, write_n, writedata, output readdata);
endinterface

// File: rtl/hdmi_tx_reset_sequencer.sv
// hdmi_tx_reset_sequencer: sequences TX PLL / TX core reset release around a qualified PLL lock
// Ports: clk, reset (sync, active-high); bus = Avalon-MM slave (CTRL@0, STATUS@1, RETRIES@2);
// pll_locked (async in); tx_pll_reset (active-high), tx_reset_n (active-low), tx_ready (high in RUN).
module hdmi_tx_reset_sequencer #(
    parameter int HOLD_CYCLES    = 16,
    parameter int LOCK_STABLE    = 64,
    parameter int LOCK_TIMEOUT   = 65536,
    parameter int RELEASE_CYCLES = 32,
    parameter int CNT_W          = 17
) (
    input  logic                      clk,
    input  logic                      reset,
    hdmi_tx_reset_sequencer_if.slave  bus,
    input  logic                      pll_locked,
    output logic                      tx_pll_reset,
    output logic                      tx_reset_n,
    output logic                      tx_ready
);
    typedef enum logic [2:0] {HOLD = 3'd0, WAIT_LOCK = 3'd1, RELEASE = 3'd2, RUN = 3'd3, FAIL = 3'd4} state_t;
    localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(LOCK_STABLE - 1);
    localparam logic [CNT_W-1:0] TMO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] REL_LAST    = CNT_W'(RELEASE_CYCLES - 1);
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, tmo_q, tmo_d;
    logic [15:0]      retries_q, retries_d;
    logic             lock_meta_q, lock_s_q;
    logic             force_q, force_d, lost_q, lost_d, tmo_stk_q, tmo_stk_d;
    logic             tx_pll_reset_q, tx_pll_reset_d, tx_reset_n_q, tx_reset_n_d, tx_ready_q, tx_ready_d;
    logic             wr, ctrl_wr, stat_wr, restart, lost_set, tmo_set;
    logic             unused;
    assign wr      = bus.chipselect & ~bus.write_n;
    assign ctrl_wr = wr && bus.address == 2'd0;
    assign stat_wr = wr && bus.address == 2'd1;
    assign restart = ctrl_wr & bus.writedata[1];
    // A CTRL write takes effect in the FSM on the same edge that stores it.
    assign force_d = ctrl_wr ? bus.writedata[0] : force_q;
    assign unused  = ^{bus.writedata[31:6], bus.writedata[3:2]};
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        retries_d = retries_q;
        lost_set  = 1'b0;
        tmo_set   = 1'b0;
        case (state_q)
            HOLD: if (cnt_q == HOLD_LAST) state_d = WAIT_LOCK; else cnt_d = cnt_q + 1'b1;
            WAIT_LOCK: begin
                // cnt holds the run of consecutive locked cycles; qualify takes priority over timeout
                cnt_d = lock_s_q ? cnt_q + 1'b1 : '0;
                if (lock_s_q && cnt_q == STABLE_LAST) state_d = RELEASE;
                else if (tmo_q == TMO_LAST) begin
                    state_d = FAIL;
                    tmo_set = 1'b1;
                end
            end
            RELEASE: if (!lock_s_q) state_d = HOLD; else if (cnt_q == REL_LAST) state_d = RUN; else cnt_d = cnt_q + 1'b1;
            RUN: if (!lock_s_q) begin
                state_d   = HOLD;
                lost_set  = 1'b1;
                retries_d = &retries_q ? retries_q : retries_q + 16'd1;
            end
            default: ;
        endcase
        if (force_d || restart) begin
            state_d   = HOLD;
            lost_set  = 1'b0;
            tmo_set   = 1'b0;
            retries_d = restart ? 16'd0 : retries_q;
        end
        if (state_d != state_q || force_d || restart) cnt_d = '0;
        tmo_d          = (state_q == WAIT_LOCK && state_d == WAIT_LOCK) ? tmo_q + 1'b1 : '0;
        lost_d         = lost_set | (lost_q & ~(stat_wr & bus.writedata[4]));
        tmo_stk_d      = tmo_set | (tmo_stk_q & ~(stat_wr & bus.writedata[5]));
        tx_pll_reset_d = state_d == HOLD || state_d == FAIL;
        tx_reset_n_d   = state_d == RUN;
        tx_ready_d     = state_d == RUN;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            lock_meta_q    <= 1'b0;
            lock_s_q       <= 1'b0;
            state_q        <= HOLD;
            cnt_q          <= '0;
            tmo_q          <= '0;
            retries_q      <= '0;
            force_q        <= 1'b0;
            lost_q         <= 1'b0;
            tmo_stk_q      <= 1'b0;
            tx_pll_reset_q <= 1'b1;
            tx_reset_n_q   <= 1'b0;
            tx_ready_q     <= 1'b0;
        end else begin
            lock_meta_q    <= pll_locked;
            lock_s_q       <= lock_meta_q;
            state_q        <= state_d;
            cnt_q          <= cnt_d;
            tmo_q          <= tmo_d;
            retries_q      <= retries_d;
            force_q        <= force_d;
            lost_q         <= lost_d;
            tmo_stk_q      <= tmo_stk_d;
            tx_pll_reset_q <= tx_pll_reset_d;
            tx_reset_n_q   <= tx_reset_n_d;
            tx_ready_q     <= tx_ready_d;
        end
    end
    assign bus.readdata = bus.address == 2'd0 ? {31'd0, force_q}
                        : bus.address == 2'd1 ? {23'd0, lock_s_q, 2'd0, tmo_stk_q, lost_q, 1'b0, state_q}
                        : bus.address == 2'd2 ? {16'd0, retries_q}
                        : 32'd0;
    assign tx_pll_reset = tx_pll_reset_q;
    assign tx_reset_n   = tx_reset_n_q;
    assign tx_ready     = tx_ready_q;
endmodule
